// File: rtl/feeder_pkg.sv
// Shared constants and state encoding for the operand feeder and its operand buffer.
package feeder_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned NUM_OPS_DEF = 4;
    localparam int unsigned RES_LAT_DEF = 3;

    // Operand slot order as the calculator expects it.
    localparam int unsigned OP_A = 0;
    localparam int unsigned OP_B = 1;
    localparam int unsigned OP_C = 2;
    localparam int unsigned OP_X = 3;

    typedef enum logic [2:0] {
        FILL     = 3'd0,
        SETUP    = 3'd1,
        PULSE    = 3'd2,
        GAP      = 3'd3,
        WAIT_RES = 3'd4,
        OUT      = 3'd5
    } state_t;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/operand_buf.sv
// Operand register file: one synchronous write port, one combinational read port, no reset.
module operand_buf
    import feeder_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned NUM_OPS = NUM_OPS_DEF,
    localparam int unsigned IDX_W  = idx_width(NUM_OPS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [NUM_OPS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/operand_feeder.sv
// Collects an operand frame, replays it to the calculator with go pulses, and returns the result.
// Define OPERAND_FEEDER_CNT_EN to add the wrapping frame_count output.
module operand_feeder
    import feeder_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned NUM_OPS = NUM_OPS_DEF,
    parameter int unsigned RES_LAT = RES_LAT_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] calc_data,
    output logic              calc_go,
    input  logic [DATA_W-1:0] calc_result,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
`ifdef OPERAND_FEEDER_CNT_EN
    output logic [7:0]        frame_count,
`endif
    input  logic              out_ready
);

    localparam int unsigned IDX_W = idx_width(NUM_OPS);
    localparam int unsigned CNT_W = idx_width(RES_LAT);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  ridx_c;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata_c;
    logic              we_c;

    assign in_ready  = (state == FILL);
    assign out_valid = (state == OUT);
    assign we_c      = in_ready & in_valid;

    // Look ahead to the operand that the next SETUP will present.
    assign ridx_c = (state == GAP) ? (idx + IDX_W'(1)) : IDX_W'(OP_A);

    operand_buf #(
        .DATA_W  (DATA_W),
        .NUM_OPS (NUM_OPS)
    ) u_buf (
        .clk   (clk),
        .we    (we_c),
        .widx  (idx),
        .wdata (in_data),
        .ridx  (ridx_c),
        .rdata (rdata_c)
    );

    // calc_data/calc_go are loaded on entry to each state so they hold for the whole state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= FILL;
            idx       <= '0;
            cnt       <= '0;
            calc_go   <= 1'b0;
            calc_data <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (we_c) begin
                        if (idx == IDX_W'(NUM_OPS - 1)) begin
                            idx       <= '0;
                            calc_data <= rdata_c;
                            state     <= SETUP;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                SETUP: begin
                    calc_go <= 1'b1;
                    state   <= PULSE;
                end
                PULSE: begin
                    calc_go <= 1'b0;
                    state   <= GAP;
                end
                GAP: begin
                    if (idx == IDX_W'(NUM_OPS - 1)) begin
                        cnt   <= '0;
                        state <= WAIT_RES;
                    end else begin
                        idx       <= idx + IDX_W'(1);
                        calc_data <= rdata_c;
                        state     <= SETUP;
                    end
                end
                WAIT_RES: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(RES_LAT - 1)) begin
                        out_data <= calc_result;
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        idx   <= '0;
                        state <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

`ifdef OPERAND_FEEDER_CNT_EN
    // Completed output handshakes, wrapping at 8 bits.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_count <= 8'd0;
        end else if (out_valid && out_ready) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder driving a behavioural A*A+C calculator.
module tb_operand_feeder;
    import feeder_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] calc_data;
    logic       calc_go;
    logic [7:0] calc_result;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
`ifdef OPERAND_FEEDER_CNT_EN
    logic [7:0] frame_count;
`endif

    int compared   = 0;
    int mismatched = 0;
    int go_count   = 0;
    int hs_count   = 0;

    logic [7:0] op_q [$];
    logic [7:0] res_q [$];

    always #5 clk = ~clk;

    operand_feeder dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .calc_data   (calc_data),
        .calc_go     (calc_go),
        .calc_result (calc_result),
        .out_valid   (out_valid),
        .out_data    (out_data),
`ifdef OPERAND_FEEDER_CNT_EN
        .frame_count (frame_count),
`endif
        .out_ready   (out_ready)
    );

    // Calculator model: latches one operand per go, result = A*A + C mod 256.
    logic       calc_rst;
    logic [7:0] ops [NUM_OPS_DEF];
    logic [1:0] n;
    logic [7:0] result_r;
    assign calc_rst    = ~resetn;
    assign calc_result = result_r;

    always @(posedge clk) begin
        if (calc_rst) begin
            n        <= 2'd0;
            result_r <= 8'd0;
        end else if (calc_go) begin
            ops[n] <= calc_data;
            n      <= n + 2'd1;
            if (n == 2'(OP_X)) begin
                result_r <= ops[OP_A] * ops[OP_A] + ops[OP_C];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    logic rst_seen;
    always @(posedge clk) begin
        rst_seen <= !resetn;
        if (resetn && out_valid && out_ready) hs_count <= hs_count + 1;
    end

    // Go-pulse monitor: data stable around a one-cycle go, operands in order.
    logic       prev_go;
    logic [7:0] prev_data;
    logic       after_go = 1'b0;
    logic [7:0] go_data;
    logic [7:0] exp_op;
    always @(negedge clk) begin
        if (after_go && !rst_seen) begin
            check("gap_data", 32'(calc_data), 32'(go_data));
            check("gap_go", 32'(calc_go), 32'd0);
        end
        after_go = 1'b0;
        if (calc_go === 1'b1) begin
            go_count++;
            check("setup_go", 32'(prev_go), 32'd0);
            check("setup_data", 32'(prev_data), 32'(calc_data));
            check("op_q_nonempty", 32'(op_q.size() != 0), 32'd1);
            if (op_q.size() != 0) begin
                exp_op = op_q.pop_front();
                check("go_data", 32'(calc_data), 32'(exp_op));
            end
            after_go = 1'b1;
            go_data  = calc_data;
        end
        prev_go   = calc_go;
        prev_data = calc_data;
    end

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] x, input bit bubbles, input int hold,
                             input bit chk_lat);
        logic [7:0] f [4];
        logic [7:0] exp_res;
        int r;
        int lat;
        f = '{a, b, c, x};
        r = int'(a) * int'(a) + int'(c);
        res_q.push_back(r[7:0]);
        out_ready = (hold == 0);
        for (int i = 0; i < 4; i++) begin
            if (bubbles) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = f[i];
            op_q.push_back(f[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (bubbles) begin
                check("busy_in_ready", 32'(in_ready), 32'd0);
                in_valid = ~in_valid;
                in_data  = 8'hEE;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("out_valid_seen", 32'(out_valid), 32'd1);
        if (chk_lat) check("latency", 32'(lat), 32'd16);
        exp_res = (res_q.size() != 0) ? res_q.pop_front() : 8'hxx;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(exp_res));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            in_valid = ~in_valid;
            in_data  = 8'hEE;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("out_data", 32'(out_data), 32'(exp_res));
        out_ready = 1'b1;
        @(negedge clk);
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int g0;
        int gocnt;
        int k;
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_go", 32'(calc_go), 32'd0);
        check("rst_data", 32'(calc_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        resetn = 1'b1;
        @(negedge clk);

        // Basic frame and overflow.
        run_frame(8'd2, 8'd0, 8'd5, 8'd7, 1'b0, 0, 1'b1);
        run_frame(8'd20, 8'd0, 8'd1, 8'd0, 1'b0, 0, 1'b1);

        // Bubbles and back-pressure.
        hs0 = hs_count;
        run_frame(8'd2, 8'd0, 8'd5, 8'd7, 1'b1, 10, 1'b0);
        check("one_handshake", 32'(hs_count - hs0), 32'd1);

        // Reset during PULSE of operand C.
        foreach (op_q[i]) op_q.delete(i);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            op_q.push_back(8'(i + 1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        gocnt = 0;
        k = 0;
        while (gocnt < 3 && k < 100) begin
            @(negedge clk);
            k++;
            if (calc_go === 1'b1) gocnt++;
        end
        check("reset_go_found", 32'(gocnt), 32'd3);
        resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_go", 32'(calc_go), 32'd0);
        check("mid_rst_data", 32'(calc_data), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        resetn = 1'b1;
        op_q.delete();
        res_q.delete();
        run_frame(8'd3, 8'd0, 8'd1, 8'd0, 1'b0, 0, 1'b1);

        // Two back-to-back frames: eight go pulses.
        g0 = go_count;
        run_frame(8'd9, 8'd1, 8'd2, 8'd3, 1'b0, 0, 1'b1);
        run_frame(8'd4, 8'd5, 8'd6, 8'd7, 1'b0, 0, 1'b1);
        check("go_pulses", 32'(go_count - g0), 32'd8);

`ifdef OPERAND_FEEDER_CNT_EN
        resetn = 1'b0;
        @(negedge clk);
        check("cnt_rst", 32'(frame_count), 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 257; i++) begin
            run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0, 1'b0);
        end
        check("cnt_wrap", 32'(frame_count), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
